bmf_qor_monitor: RTL and testbench

- Streaming quality-of-result monitor placed directly downstream of an approximated partition (compressor w + decompressor h).
- Consumes, per input vector, the approximate partition outputs alongside the exact partition outputs for the same vector.
- Accumulates error statistics over a programmed number of samples: error count, summed absolute error, maximum absolute error and summed Hamming distance.
- Results feed the BMF-degree (k) selection loop.

---
 rtl/bmf_qor_pkg.sv | 26 ++
 rtl/bmf_err_calc.sv | 30 +++
 rtl/bmf_qor_monitor.sv | 134 +++++++++++++
 tb/tb_bmf_qor_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bmf_qor_pkg.sv
// Shared types and helpers for the BMF quality-of-result monitor.
// Holds the FSM state encoding, default widths and a saturating adder.
package bmf_qor_pkg;

  localparam int DEF_OUT_W = 4;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_SUM_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Adds two values and clamps the result to the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (33'd1 << w) - 33'd1;
    return (s > mx) ? mx[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/bmf_err_calc.sv
// Combinational per-sample error terms: |a-b|, mismatch flag and Hamming distance.
module bmf_err_calc
  import bmf_qor_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W,
  parameter int HW    = $clog2(DEF_OUT_W + 1)
) (
  input  logic [OUT_W-1:0] a_i,
  input  logic [OUT_W-1:0] b_i,
  output logic [OUT_W-1:0] d_o,
  output logic             mismatch_o,
  output logic [HW-1:0]    h_o
);

  logic signed [OUT_W:0] diff;
  logic [OUT_W-1:0]      x;

  always_comb begin
    diff = $signed({1'b0, a_i}) - $signed({1'b0, b_i});
    // Magnitude of an (OUT_W+1)-bit difference always fits back into OUT_W bits.
    d_o  = diff[OUT_W] ? OUT_W'(-diff) : OUT_W'(diff);
    x    = a_i ^ b_i;
    mismatch_o = |x;
    h_o  = '0;
    for (int i = 0; i < OUT_W; i++) begin
      h_o = h_o + HW'(x[i]);
    end
  end

endmodule

// File: rtl/bmf_qor_monitor.sv
// Streaming error-statistics monitor comparing exact vs approximate partition outputs.
// Stage 1 registers per-sample error terms; stage 2 folds them into saturating accumulators.
module bmf_qor_monitor
  import bmf_qor_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] exact,
  input  logic [OUT_W-1:0] approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] err_sum,
  output logic [OUT_W-1:0] err_max,
  output logic [SUM_W-1:0] ham_sum,
  output logic [1:0]       dbg_state_o
);

  localparam int HW = $clog2(OUT_W + 1);

  state_t           state_q;
  logic [CNT_W-1:0] target_q, acc_q;
  logic             s1_valid_q, s1_mis_q;
  logic [OUT_W-1:0] s1_d_q;
  logic [HW-1:0]    s1_h_q;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d, err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0] err_sum_q, err_sum_d, ham_sum_q, ham_sum_d;
  logic [OUT_W-1:0] err_max_q, err_max_d;

  logic [OUT_W-1:0] calc_d;
  logic             calc_mis;
  logic [HW-1:0]    calc_h;
  logic             xfer;

  bmf_err_calc #(.OUT_W(OUT_W), .HW(HW)) u_err_calc (
    .a_i       (exact),
    .b_i       (approx),
    .d_o       (calc_d),
    .mismatch_o(calc_mis),
    .h_o       (calc_h)
  );

  // Handshake: a sample transfers on any cycle where in_valid and in_ready are both high.
  assign in_ready = (state_q == ST_RUN) && (acc_q < target_q);
  assign xfer     = in_valid & in_ready;

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_sum_d    = err_sum_q;
    ham_sum_d    = ham_sum_q;
    err_max_d    = err_max_q;
    if (s1_valid_q) begin
      sample_cnt_d = CNT_W'(sat_add(32'(sample_cnt_q), 32'd1, CNT_W));
      err_cnt_d    = CNT_W'(sat_add(32'(err_cnt_q), 32'(s1_mis_q), CNT_W));
      err_sum_d    = SUM_W'(sat_add(32'(err_sum_q), 32'(s1_d_q), SUM_W));
      ham_sum_d    = SUM_W'(sat_add(32'(ham_sum_q), 32'(s1_h_q), SUM_W));
      err_max_d    = (s1_d_q > err_max_q) ? s1_d_q : err_max_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      target_q     <= '0;
      acc_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_mis_q     <= 1'b0;
      s1_d_q       <= '0;
      s1_h_q       <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      err_sum_q    <= '0;
      ham_sum_q    <= '0;
      err_max_q    <= '0;
    end else begin
      s1_valid_q <= xfer;
      if (xfer) begin
        s1_d_q   <= calc_d;
        s1_mis_q <= calc_mis;
        s1_h_q   <= calc_h;
      end
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_sum_q    <= err_sum_d;
      ham_sum_q    <= ham_sum_d;
      err_max_q    <= err_max_d;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // Stage 1 is always empty here, so clearing cannot drop a pending sample.
          if (start) begin
            target_q     <= num_samples;
            acc_q        <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            err_sum_q    <= '0;
            ham_sum_q    <= '0;
            err_max_q    <= '0;
            state_q      <= (num_samples == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            acc_q <= acc_q + CNT_W'(1);
            if (acc_q + CNT_W'(1) == target_q) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!s1_valid_q) state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign sample_cnt  = sample_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign err_sum     = err_sum_q;
  assign err_max     = err_max_q;
  assign ham_sum     = ham_sum_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bmf_qor_monitor.sv
// Directed bench for bmf_qor_monitor: table-driven runs plus hand-written corner sequences.
module tb_bmf_qor_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] num_samples = '0;
  logic [3:0]  exact = '0;
  logic [3:0]  approx = '0;

  logic        in_ready, busy, done;
  logic [15:0] sample_cnt, err_cnt;
  logic [23:0] err_sum, ham_sum;
  logic [3:0]  err_max;
  logic [1:0]  dbg_state;

  logic        s_in_ready, s_busy, s_done;
  logic [3:0]  s_sample_cnt, s_err_cnt, s_err_sum, s_err_max, s_ham_sum;
  logic [1:0]  s_dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int          kind;
    logic [15:0] n;
    logic [31:0] cnt, errs, sum, mx, ham;
  } run_vec_t;
  run_vec_t vecs[4];

  int xfers, t3, done_c, ready_viol;
  logic [3:0] ge, ga;

  bmf_qor_monitor #(.OUT_W(4), .CNT_W(16), .SUM_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .exact(exact), .approx(approx),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .err_sum(err_sum), .err_max(err_max), .ham_sum(ham_sum), .dbg_state_o(dbg_state)
  );

  bmf_qor_monitor #(.OUT_W(4), .CNT_W(4), .SUM_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples[3:0]),
    .in_valid(in_valid), .in_ready(s_in_ready), .exact(exact), .approx(approx),
    .busy(s_busy), .done(s_done), .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt),
    .err_sum(s_err_sum), .err_max(s_err_max), .ham_sum(s_ham_sum), .dbg_state_o(s_dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic start_run(input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    num_samples = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] e, input logic [3:0] a);
    int t;
    t = 0;
    exact = e;
    approx = a;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) check("send_ready_timeout", 32'(in_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (!done && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    check("done_seen", 32'(done), 1);
  endtask

  task automatic push_exp(input logic [31:0] c, e, s, m, h);
    exp_q.push_back(c); exp_q.push_back(e); exp_q.push_back(s);
    exp_q.push_back(m); exp_q.push_back(h);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_sample_cnt"}, 32'(sample_cnt), exp_q.pop_front());
    check({tag, "_err_cnt"},    32'(err_cnt),    exp_q.pop_front());
    check({tag, "_err_sum"},    32'(err_sum),    exp_q.pop_front());
    check({tag, "_err_max"},    32'(err_max),    exp_q.pop_front());
    check({tag, "_ham_sum"},    32'(ham_sum),    exp_q.pop_front());
  endtask

  function automatic void gen(input int kind, input int i, output logic [3:0] e,
                              output logic [3:0] a);
    logic [3:0] v;
    v = 4'(i);
    case (kind)
      0: begin e = 4'h9; a = 4'h9; end
      1: begin e = v; a = v & 4'hE; end
      2: case (i)
           0:       begin e = 4'd15; a = 4'd0;  end
           1:       begin e = 4'd0;  a = 4'd15; end
           2:       begin e = 4'd5;  a = 4'd6;  end
           default: begin e = 4'd7;  a = 4'd7;  end
         endcase
      default: begin e = v; a = ~v; end
    endcase
  endfunction

  initial begin
    vecs[0] = '{0, 16'd16, 16, 0,  0,   0,  0};
    vecs[1] = '{1, 16'd16, 16, 8,  8,   1,  8};
    vecs[2] = '{2, 16'd4,  4,  3,  31,  15, 10};
    vecs[3] = '{3, 16'd16, 16, 16, 128, 15, 64};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    push_exp(0, 0, 0, 0, 0);
    check_stats("rst");
    rst_n = 1'b1;

    // Table-driven runs, samples offered back-to-back.
    for (int v = 0; v < 4; v++) begin
      start_run(vecs[v].n);
      check($sformatf("vec%0d_busy", v), 32'(busy), 1);
      check($sformatf("vec%0d_done_low", v), 32'(done), 0);
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        gen(vecs[v].kind, i, ge, ga);
        send(ge, ga);
      end
      in_valid = 1'b0;
      wait_done(20);
      check($sformatf("vec%0d_ready_low", v), 32'(in_ready), 0);
      push_exp(vecs[v].cnt, vecs[v].errs, vecs[v].sum, vecs[v].mx, vecs[v].ham);
      check_stats($sformatf("vec%0d", v));
    end

    // Valid gaps: pattern 1,0,1,0,1 then held high against a 3-sample target.
    start_run(16'd3);
    xfers = 0; t3 = -1; done_c = -1; ready_viol = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 5) ? ((c % 2) == 0) : 1'b1;
      exact = 4'd3;
      approx = 4'd1;
      if (xfers >= 3 && in_ready) ready_viol++;
      if (done && done_c < 0) done_c = c;
      if (in_valid && in_ready) begin
        xfers++;
        if (xfers == 3) t3 = c;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_transfers", 32'(xfers), 3);
    check("bp_third_xfer_cycle", 32'(t3), 4);
    check("bp_ready_after_last", 32'(ready_viol), 0);
    check("bp_done_gap", 32'((done_c >= 0) && (done_c - t3 >= 2)), 1);
    push_exp(3, 3, 6, 2, 3);
    check_stats("bp");

    // Start during RUN is ignored.
    start_run(16'd4);
    gen(2, 0, ge, ga); send(ge, ga);
    gen(2, 1, ge, ga); send(ge, ga);
    in_valid = 1'b0;
    start = 1'b1;
    num_samples = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    check("midstart_busy", 32'(busy), 1);
    gen(2, 2, ge, ga); send(ge, ga);
    gen(2, 3, ge, ga); send(ge, ga);
    in_valid = 1'b0;
    wait_done(20);
    push_exp(4, 3, 31, 15, 10);
    check_stats("midstart");

    // Zero-length run completes one cycle after start with cleared statistics.
    start_run(16'd0);
    check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 0);
    check("zero_state", 32'(dbg_state), 3);
    push_exp(0, 0, 0, 0, 0);
    check_stats("zero");

    // Saturation: the narrow instance sees the same 15-sample stream of worst-case errors.
    start_run(16'd15);
    for (int i = 0; i < 15; i++) send(4'd15, 4'd0);
    in_valid = 1'b0;
    wait_done(20);
    push_exp(15, 15, 225, 15, 60);
    check_stats("wide");
    check("sat_done", 32'(s_done), 1);
    check("sat_sample_cnt", 32'(s_sample_cnt), 15);
    check("sat_err_cnt", 32'(s_err_cnt), 15);
    check("sat_err_sum", 32'(s_err_sum), 15);
    check("sat_err_max", 32'(s_err_max), 15);
    check("sat_ham_sum", 32'(s_ham_sum), 15);

    // Asynchronous reset after 5 of 10 samples discards partial statistics.
    start_run(16'd10);
    for (int i = 0; i < 5; i++) send(4'd12, 4'd3);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("prerst_sample_cnt", 32'(sample_cnt), 5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(dbg_state), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_done", 32'(done), 0);
    push_exp(0, 0, 0, 0, 0);
    check_stats("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
